// File: rtl/panda_register_file_mp.sv
// Multi-port integer register file with a per-register busy scoreboard.
// Reads are combinational with optional same-cycle write forwarding.

module panda_rf_rd_lane #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NW     = 2,
  parameter int BYPASS = 1,
  parameter int AW     = 5
) (
  input  logic [AW-1:0]                 addr_i,
  input  logic [DEPTH-1:0][XLEN-1:0]    regs_i,
  input  logic [DEPTH-1:0]              busy_i,
  input  logic [NW*AW-1:0]              wr_addr_i,
  input  logic [NW*XLEN-1:0]            wr_data_i,
  input  logic [NW-1:0]                 wr_we_i,
  output logic [XLEN-1:0]               data_o,
  output logic                          busy_o
);
  always_comb begin
    data_o = regs_i[addr_i];
    // Ascending scan so the highest-numbered write port wins the forward.
    if (BYPASS != 0) begin
      for (int w = 0; w < NW; w++) begin
        if (wr_we_i[w] && wr_addr_i[w*AW +: AW] == addr_i)
          data_o = wr_data_i[w*XLEN +: XLEN];
      end
    end
    if (addr_i == '0) data_o = '0;
  end

  assign busy_o = busy_i[addr_i];
endmodule

module panda_register_file_mp #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NR     = 2,
  parameter int NW     = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NR*AW-1:0]     rs_addr_i,
  output logic [NR*XLEN-1:0]   rs_data_o,
  output logic [NR-1:0]        rs_busy_o,
  input  logic [NW*AW-1:0]     wr_addr_i,
  input  logic [NW*XLEN-1:0]   wr_data_i,
  input  logic [NW-1:0]        wr_we_i,
  input  logic [AW-1:0]        issue_addr_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  output logic [AW:0]          busy_cnt_o
);
  logic [DEPTH-1:0][XLEN-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]           busy_q, busy_d;
  logic [AW:0]                cnt_q, cnt_d;
  logic [AW-1:0]              wa;
  logic                       clr_hit;

  always_comb begin
    regs_d        = regs_q;
    busy_d        = busy_q;
    clr_hit       = 1'b0;
    wa            = '0;
    issue_ready_o = 1'b0;
    cnt_d         = '0;
    for (int w = 0; w < NW; w++) begin
      wa = wr_addr_i[w*AW +: AW];
      if (wr_we_i[w] && wa != '0) begin
        regs_d[wa] = wr_data_i[w*XLEN +: XLEN];
        busy_d[wa] = 1'b0;
        if (wa == issue_addr_i) clr_hit = 1'b1;
      end
    end
    issue_ready_o = (issue_addr_i == '0) || !busy_q[issue_addr_i] || clr_hit;
    // Set is applied after the write clears so a same-cycle reservation wins.
    if (issue_valid_i && issue_ready_o && issue_addr_i != '0)
      busy_d[issue_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      cnt_d = cnt_d + (AW+1)'(busy_d[i]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      regs_q <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt_o = cnt_q;

  for (genvar k = 0; k < NR; k++) begin : g_rd
    panda_rf_rd_lane #(
      .XLEN(XLEN), .DEPTH(DEPTH), .NW(NW), .BYPASS(BYPASS), .AW(AW)
    ) u_lane (
      .addr_i   (rs_addr_i[k*AW +: AW]),
      .regs_i   (regs_q),
      .busy_i   (busy_q),
      .wr_addr_i(wr_addr_i),
      .wr_data_i(wr_data_i),
      .wr_we_i  (wr_we_i),
      .data_o   (rs_data_o[k*XLEN +: XLEN]),
      .busy_o   (rs_busy_o[k])
    );
  end
endmodule
